// File: rtl/imem_fetch.sv
`default_nettype none
// ============================================================================
// Module   : imem_fetch
// Purpose  : Instruction memory with a clear sweep after reset, a one-cycle
//            fetch port and a program-load port with write-first bypass.
//            Define IMEM_PARITY_EN to store and check an even-parity bit.
// Revision : 1.0
// ============================================================================
module imem_fetch #(
    parameter int IW    = 19,
    parameter int AW    = 12,
    parameter int DEPTH = 4096
) (
    input  logic          clk,
    input  logic          rst,
    output logic          init_done,
    input  logic          fetch_req,
    input  logic [AW-1:0] fetch_addr,
    output logic          fetch_rdy,
    output logic          instr_valid,
    output logic [IW-1:0] instr,
    output logic          addr_err,
    input  logic          load_we,
    input  logic [AW-1:0] load_addr,
    input  logic [IW-1:0] load_data,
    output logic          load_ack,
    output logic          parity_err
);

`ifdef IMEM_PARITY_EN
    localparam int c_SW = IW + 1;
`else
    localparam int c_SW = IW;
`endif
    localparam int            c_MW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   c_DEPTH = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] c_LAST  = AW'(DEPTH - 1);

    localparam logic [0:0] S_CLEAR = 1'b0;
    localparam logic [0:0] S_RUN   = 1'b1;

    logic [0:0]      r_state;
    logic [0:0]      w_next_state;
    logic [AW-1:0]   r_clr_ptr;
    logic [c_SW-1:0] r_mem [0:DEPTH-1];

    logic            r_instr_valid;
    logic [IW-1:0]   r_instr;
    logic            r_addr_err;
    logic            r_load_ack;

    logic            w_fetch_ok;
    logic            w_fetch_in;
    logic            w_load_in;
    logic            w_load_ok;
    logic            w_bypass;
    logic            w_we;
    logic [c_MW-1:0] w_waddr;
    logic [c_SW-1:0] w_wdata;
    logic [c_SW-1:0] w_load_word;
    logic [c_SW-1:0] w_rd_word;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_CLEAR;
            r_clr_ptr <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == S_CLEAR)
                r_clr_ptr <= r_clr_ptr + 1'b1;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (r_state == S_CLEAR && r_clr_ptr == c_LAST)
            w_next_state = S_RUN;
    end

    always_comb begin
        init_done = (r_state == S_RUN);
        fetch_rdy = (r_state == S_RUN);
    end

    // ---------------- datapath ----------------
`ifdef IMEM_PARITY_EN
    assign w_load_word = {^load_data, load_data};
`else
    assign w_load_word = load_data;
`endif

    assign w_fetch_ok = fetch_req & fetch_rdy;
    assign w_fetch_in = ({1'b0, fetch_addr} < c_DEPTH);
    assign w_load_in  = ({1'b0, load_addr} < c_DEPTH);
    assign w_load_ok  = load_we & (r_state == S_RUN) & w_load_in;
    assign w_bypass   = w_load_ok & (load_addr == fetch_addr);

    // The clear sweep owns the single write port until RUN.
    assign w_we    = (r_state == S_CLEAR) | w_load_ok;
    assign w_waddr = (r_state == S_CLEAR) ? r_clr_ptr[c_MW-1:0] : load_addr[c_MW-1:0];
    assign w_wdata = (r_state == S_CLEAR) ? '0 : w_load_word;

    assign w_rd_word = w_bypass ? w_load_word : r_mem[fetch_addr[c_MW-1:0]];

    always_ff @(posedge clk) begin
        if (w_we)
            r_mem[w_waddr] <= w_wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_instr_valid <= 1'b0;
            r_instr       <= '0;
            r_addr_err    <= 1'b0;
            r_load_ack    <= 1'b0;
        end else begin
            r_instr_valid <= w_fetch_ok;
            r_addr_err    <= w_fetch_ok & ~w_fetch_in;
            r_load_ack    <= w_load_ok;
            if (w_fetch_ok)
                r_instr <= w_fetch_in ? w_rd_word[IW-1:0] : '0;
        end
    end

`ifdef IMEM_PARITY_EN
    logic r_parity_err;

    // Even parity: a good stored word XORs to zero including its parity bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_parity_err <= 1'b0;
        else
            r_parity_err <= w_fetch_ok & w_fetch_in & (^w_rd_word);
    end
    assign parity_err = r_parity_err;
`else
    assign parity_err = 1'b0;
`endif

    assign instr_valid = r_instr_valid;
    assign instr       = r_instr;
    assign addr_err    = r_addr_err;
    assign load_ack    = r_load_ack;

endmodule
`default_nettype wire

// File: tb/tb_imem_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_fetch
// Purpose  : Scoreboard bench for imem_fetch (DEPTH=16) with a memory model.
// Revision : 1.0
// ============================================================================
module tb_imem_fetch;
    localparam int IW    = 19;
    localparam int AW    = 12;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          init_done;
    logic          fetch_req = 1'b0;
    logic [AW-1:0] fetch_addr = '0;
    logic          fetch_rdy;
    logic          instr_valid;
    logic [IW-1:0] instr;
    logic          addr_err;
    logic          load_we = 1'b0;
    logic [AW-1:0] load_addr = '0;
    logic [IW-1:0] load_data = '0;
    logic          load_ack;
    logic          parity_err;

    imem_fetch #(.IW(IW), .AW(AW), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .init_done  (init_done),
        .fetch_req  (fetch_req),
        .fetch_addr (fetch_addr),
        .fetch_rdy  (fetch_rdy),
        .instr_valid(instr_valid),
        .instr      (instr),
        .addr_err   (addr_err),
        .load_we    (load_we),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .load_ack   (load_ack),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            cyc;
        logic [IW-1:0] instr;
        logic          aerr;
        logic          perr;
    } fexp_t;

    fexp_t         fq[$];
    int            aq[$];
    logic [IW-1:0] mdl_mem [DEPTH];
    bit            mdl_perr[DEPTH];
    int            checks = 0;
    int            errors = 0;
    int            cyc    = 0;
    int            edges  = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) edges <= 0;
        else     edges <= edges + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock edge of stimulus; the model decides what that edge must produce.
    task automatic step(input bit fr, input int fa, input bit lw, input int la,
                        input logic [IW-1:0] ld);
        fexp_t e;
        bit    run;
        @(posedge clk);
        #1;
        fetch_req  = fr;
        fetch_addr = AW'(fa);
        load_we    = lw;
        load_addr  = AW'(la);
        load_data  = ld;
        run = (edges >= DEPTH);
        if (run && fr) begin
            e.cyc = cyc + 1;
            if (fa < DEPTH) begin
                e.aerr  = 1'b0;
                e.instr = (lw && la == fa) ? ld : mdl_mem[fa];
                e.perr  = (lw && la == fa) ? 1'b0 : mdl_perr[fa];
            end else begin
                e.aerr  = 1'b1;
                e.instr = '0;
                e.perr  = 1'b0;
            end
            fq.push_back(e);
        end
        if (run && lw && la < DEPTH) begin
            mdl_mem[la]  = ld;
            mdl_perr[la] = 1'b0;
            aq.push_back(cyc + 1);
        end
    endtask

    task automatic idle();
        step(1'b0, 0, 1'b0, 0, '0);
    endtask

    // Asserts reset immediately, checks outputs drop, then verifies the clear sweep.
    task automatic do_reset();
        fq.delete();
        aq.delete();
        rst       = 1'b1;
        fetch_req = 1'b0;
        load_we   = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            mdl_mem[i]  = '0;
            mdl_perr[i] = 1'b0;
        end
        #1;
        check("rst_instr_valid", 32'(instr_valid), 0);
        check("rst_instr",       32'(instr),       0);
        check("rst_addr_err",    32'(addr_err),    0);
        check("rst_load_ack",    32'(load_ack),    0);
        check("rst_parity_err",  32'(parity_err),  0);
        check("rst_init_done",   32'(init_done),   0);
        check("rst_fetch_rdy",   32'(fetch_rdy),   0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int j = 1; j <= DEPTH; j++) begin
            // Loads aimed at clear-phase edges must be dropped.
            step(1'b0, 0, (j < DEPTH), $urandom_range(0, DEPTH - 1), IW'($urandom | 1));
            check("clear_init_done", 32'(init_done), (j >= DEPTH) ? 1 : 0);
            check("clear_fetch_rdy", 32'(fetch_rdy), (j >= DEPTH) ? 1 : 0);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (instr_valid) begin
                if (fq.size() == 0) begin
                    check("valid_spurious", 1, 0);
                end else begin
                    fexp_t e;
                    e = fq.pop_front();
                    check("fetch_cycle", 32'(cyc),        32'(e.cyc));
                    check("instr",       32'(instr),      32'(e.instr));
                    check("addr_err",    32'(addr_err),   32'(e.aerr));
                    check("parity_err",  32'(parity_err), 32'(e.perr));
                end
            end else if (fq.size() > 0 && fq[0].cyc <= cyc) begin
                check("valid_missing", 0, 1);
                void'(fq.pop_front());
            end
            if (load_ack) begin
                if (aq.size() == 0) begin
                    check("ack_spurious", 1, 0);
                end else begin
                    int c;
                    c = aq.pop_front();
                    check("ack_cycle", 32'(cyc), 32'(c));
                end
            end else if (aq.size() > 0 && aq[0] <= cyc) begin
                check("ack_missing", 0, 1);
                void'(aq.pop_front());
            end
        end
    end

    initial begin : main
        logic [IW-1:0] w7;
        w7 = {2'b00, 3'b000, 3'b011, 3'b001, 3'b010, 5'b00110};

        do_reset();

        // Everything cleared, including words targeted by clear-phase loads.
        for (int a = 0; a < DEPTH; a++) step(1'b1, a, 1'b0, 0, '0);
        idle();

        step(1'b0, 0, 1'b1, 7, w7);
        step(1'b1, 7, 1'b0, 0, '0);
        step(1'b0, 0, 1'b1, 8, 19'h2A5A5);
        step(1'b0, 0, 1'b1, 9, 19'h13C3C);
        step(1'b1, 7, 1'b0, 0, '0);
        step(1'b1, 8, 1'b0, 0, '0);
        step(1'b1, 9, 1'b0, 0, '0);
        step(1'b1, 10, 1'b1, 10, 19'h4FFFF);
        idle();
        idle();
        check("instr_hold", 32'(instr), 32'h4FFFF);
        step(1'b1, 20, 1'b0, 0, '0);
        step(1'b0, 0, 1'b1, 20, 19'h12345);
        step(1'b1, DEPTH - 1, 1'b1, DEPTH, 19'h7FFFF);
        step(1'b1, DEPTH, 1'b0, 0, '0);
        idle();

`ifdef IMEM_PARITY_EN
        idle();
        dut.r_mem[8][0] = ~dut.r_mem[8][0];
        mdl_mem[8][0]   = ~mdl_mem[8][0];
        mdl_perr[8]     = 1'b1;
        step(1'b1, 8, 1'b0, 0, '0);
        step(1'b1, 9, 1'b0, 0, '0);
        idle();
`endif

        for (int n = 0; n < 400; n++) begin
            int fa;
            int la;
            fa = ($urandom_range(0, 15) == 0) ? $urandom_range(DEPTH, (1 << AW) - 1)
                                             : $urandom_range(0, DEPTH + 7);
            la = $urandom_range(0, DEPTH + 7);
            step($urandom_range(0, 1) == 1, fa, $urandom_range(0, 1) == 1, la, IW'($urandom));
        end

        // Mid-run reset while a result is on the outputs.
        step(1'b1, 7, 1'b0, 0, '0);
        step(1'b1, 7, 1'b1, 7, 19'h00001);
        #3;
        do_reset();

        for (int n = 0; n < 40; n++)
            step($urandom_range(0, 1) == 1, $urandom_range(0, DEPTH + 3), 1'b0, 0, '0);
        repeat (3) idle();
        check("fetch_queue_drained", 32'(fq.size()), 0);
        check("ack_queue_drained",   32'(aq.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
